// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side handshake, flush, execute-side handshake and decoded bundle of decode_stage
// slave: the stage (takes in_valid/inst/out_ready/flush, drives in_ready/out_valid/bundle/stall_count)
// master: the environment around the stage (fetch buffer, execute stage, branch unit)
interface decode_stage_if #(
  parameter int INST_W = 32,
  parameter int REG_W = 5,
  parameter int BADDR_W = 21,
  parameter int ALUOP_W = 12,
  parameter int STALL_CNT_W = 16
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [INST_W-1:0] inst;
  logic out_valid;
  logic out_ready;
  logic mem_write;
  logic alu_src;
  logic alu_reg_write;
  logic mem_reg_write;
  logic long_write;
  logic branch;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [INST_W-1:0] imm;
  logic [BADDR_W-1:0] baddr;
  logic [ALUOP_W-1:0] aluop;
  logic [STALL_CNT_W-1:0] stall_count;
  modport slave (
    input flush, in_valid, inst, out_ready,
    output in_ready, out_valid, mem_write, alu_src, alu_reg_write, mem_reg_write, long_write, branch,
    output rs, rt, rd, imm, baddr, aluop, stall_count
  );
  modport master (
    output flush, in_valid, inst, out_ready,
    input in_ready, out_valid, mem_write, alu_src, alu_reg_write, mem_reg_write, long_write, branch,
    input rs, rt, rd, imm, baddr, aluop, stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with load-use interlock, flush and saturating stall counter
// clk, rst_n (async active-low) plain; everything else on bus (decode_stage_if.slave).
// Control decode: 00 R-type, 08 addi, 23 load, 2b store, 04 branch, 03 long (link) write; others no flags.
module decode_stage #(
  parameter int INST_W = 32,
  parameter int REG_W = 5,
  parameter int IMM_W = 16,
  parameter int BADDR_W = 21,
  parameter int ALUOP_W = 12,
  parameter int SIGN_EXT = 1,
  parameter int STALL_CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  decode_stage_if.slave bus
);
  logic [5:0] op;
  logic d_mem_write, d_alu_src, d_alu_reg_write, d_mem_reg_write, d_long_write, d_branch;
  logic [REG_W-1:0] d_rs, d_rt, d_rd;
  logic [INST_W-1:0] d_imm;
  logic reads_rt, hazard, accept;
  assign op = bus.inst[INST_W-1 -: 6];
  assign d_alu_reg_write = op == 6'h00 || op == 6'h08;
  assign d_alu_src = op == 6'h08 || op == 6'h23 || op == 6'h2b;
  assign d_mem_reg_write = op == 6'h23;
  assign d_mem_write = op == 6'h2b;
  assign d_branch = op == 6'h04;
  assign d_long_write = op == 6'h03;
  assign d_rs = bus.inst[INST_W-7 -: REG_W];
  assign d_rt = bus.inst[INST_W-7-REG_W -: REG_W];
  assign d_rd = bus.inst[INST_W-7-2*REG_W -: REG_W];
  assign d_imm = {{(INST_W-IMM_W){SIGN_EXT != 0 && bus.inst[IMM_W-1]}}, bus.inst[IMM_W-1:0]};
  assign reads_rt = !d_alu_src || d_mem_write || d_branch;
  // The held bundle is a load whose target the incoming instruction needs; r0 is never a real dependency.
  assign hazard = bus.out_valid && bus.mem_reg_write && bus.rt != '0 &&
                  (d_rs == bus.rt || (reads_rt && d_rt == bus.rt));
  assign bus.in_ready = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.alu_src <= 1'b0;
      bus.alu_reg_write <= 1'b0;
      bus.mem_reg_write <= 1'b0;
      bus.long_write <= 1'b0;
      bus.branch <= 1'b0;
      bus.rs <= '0;
      bus.rt <= '0;
      bus.rd <= '0;
      bus.imm <= '0;
      bus.baddr <= '0;
      bus.aluop <= '0;
      bus.stall_count <= '0;
    end else begin
      if (bus.flush) begin
        bus.out_valid <= 1'b0;
      end else if (accept) begin
        bus.out_valid <= 1'b1;
        bus.mem_write <= d_mem_write;
        bus.alu_src <= d_alu_src;
        bus.alu_reg_write <= d_alu_reg_write;
        bus.mem_reg_write <= d_mem_reg_write;
        bus.long_write <= d_long_write;
        bus.branch <= d_branch;
        bus.rs <= d_rs;
        bus.rt <= d_rt;
        bus.rd <= d_rd;
        bus.imm <= d_imm;
        bus.baddr <= bus.inst[BADDR_W-1:0];
        bus.aluop <= bus.inst[ALUOP_W-1:0];
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (bus.in_valid && hazard && !bus.flush && bus.stall_count != '1)
        bus.stall_count <= bus.stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (default instance plus SIGN_EXT=0 / STALL_CNT_W=2 shadow)
module tb_decode_stage;
  typedef struct packed {
    logic mem_write, alu_src, alu_reg_write, mem_reg_write, long_write, branch;
    logic [4:0] rs, rt, rd;
    logic [31:0] imm;
    logic [20:0] baddr;
    logic [11:0] aluop;
  } bundle_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  bundle_t sb[$];
  bundle_t snap, e;
  logic [31:0] stream [4] = '{32'h10220003, 32'h0C00ABCD, 32'hAC850008, 32'h2003FFFF};
  decode_stage_if a ();
  decode_stage_if #(.STALL_CNT_W(2)) b ();
  decode_stage dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  decode_stage #(.SIGN_EXT(0), .STALL_CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  assign b.flush = a.flush;
  assign b.in_valid = a.in_valid;
  assign b.inst = a.inst;
  assign b.out_ready = a.out_ready;
  always #5 clk = ~clk;
  function automatic bundle_t model(input logic [31:0] i);
    bundle_t m;
    m = '0;
    case (i[31:26])
      6'h00: m.alu_reg_write = 1'b1;
      6'h08: begin m.alu_src = 1'b1; m.alu_reg_write = 1'b1; end
      6'h23: begin m.alu_src = 1'b1; m.mem_reg_write = 1'b1; end
      6'h2b: begin m.alu_src = 1'b1; m.mem_write = 1'b1; end
      6'h04: m.branch = 1'b1;
      6'h03: m.long_write = 1'b1;
      default: ;
    endcase
    m.rs = i[25:21];
    m.rt = i[20:16];
    m.rd = i[15:11];
    m.imm = {{16{i[15]}}, i[15:0]};
    m.baddr = i[20:0];
    m.aluop = i[11:0];
    return m;
  endfunction
  function automatic bundle_t seen();
    return bundle_t'({a.mem_write, a.alu_src, a.alu_reg_write, a.mem_reg_write, a.long_write, a.branch,
                      a.rs, a.rt, a.rd, a.imm, a.baddr, a.aluop});
  endfunction
  function automatic bundle_t pop();
    bundle_t r;
    r = 'x;
    if (sb.size() != 0) r = sb.pop_front();
    return r;
  endfunction
  task automatic test_reset;
    a.flush = 1'b0;
    a.in_valid = 1'b0;
    a.inst = '0;
    a.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    a.flush = 1'b1;
    #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a.out_valid); end
    checks++; if (seen() !== bundle_t'('0)) begin failures++; $display("FAIL reset_bundle got=%h exp=0", seen()); end
    checks++; if (a.stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", a.stall_count); end
    @(negedge clk);
    a.flush = 1'b0;
    #1;
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a.in_ready); end
    rst_n = 1'b1;
  endtask
  task automatic test_plain_flow;
    a.out_ready = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h2022FFFC;
    sb.push_back(model(a.inst));
    #1;
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL flow_in_ready got=%b exp=1", a.in_ready); end
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL flow_out_valid got=%b exp=1", a.out_valid); end
    checks++; if (seen() !== e) begin failures++; $display("FAIL flow_bundle got=%h exp=%h", seen(), e); end
    checks++; if (a.rs !== 5'd1 || a.rt !== 5'd2) begin failures++; $display("FAIL flow_regs got=%0d/%0d exp=1/2", a.rs, a.rt); end
    checks++; if (a.imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL flow_imm_sext got=%h exp=fffffffc", a.imm); end
    checks++; if (b.imm !== 32'h0000FFFC) begin failures++; $display("FAIL flow_imm_zext got=%h exp=0000fffc", b.imm); end
    @(negedge clk);
    #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL flow_drain got=%b exp=0", a.out_valid); end
  endtask
  task automatic test_backpressure;
    a.out_ready = 1'b0;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h00643020;
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.inst = 32'hAC850008;
    #1;
    snap = seen();
    checks++; if (a.out_valid !== 1'b1 || snap !== sb[0]) begin failures++; $display("FAIL bp_first got=%h exp=%h", snap, sb[0]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (a.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", a.in_ready); end
      @(negedge clk);
      #1;
      checks++; if (a.out_valid !== 1'b1 || seen() !== snap) begin failures++; $display("FAIL bp_hold got=%h exp=%h", seen(), snap); end
    end
    a.out_ready = 1'b1;
    #1;
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", a.in_ready); end
    void'(pop());
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL bp_next got=%h exp=%h", seen(), e); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    a.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a.in_valid = 1'b1;
      a.inst = stream[k];
      #1;
      if (k > 0) begin
        e = pop();
        checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL b2b_out%0d got=%h exp=%h", k, seen(), e); end
      end
      sb.push_back(model(a.inst));
      checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready%0d got=%b exp=1", k, a.in_ready); end
    end
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL b2b_last got=%h exp=%h", seen(), e); end
    @(negedge clk);
  endtask
  task automatic test_load_use;
    a.out_ready = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h8C250000;
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.inst = 32'h00A63820;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL lu_load got=%h exp=%h", seen(), e); end
    checks++; if (a.in_ready !== 1'b0) begin failures++; $display("FAIL lu_hazard got=%b exp=0", a.in_ready); end
    @(negedge clk);
    #1;
    exp_stall++;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", a.out_valid); end
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL lu_resume got=%b exp=1", a.in_ready); end
    checks++; if (a.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL lu_stall got=%0d exp=%0d", a.stall_count, exp_stall); end
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL lu_dependent got=%h exp=%h", seen(), e); end
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h8C200000;
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.inst = 32'h00063820;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL lu0_load got=%h exp=%h", seen(), e); end
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL lu0_no_hazard got=%b exp=1", a.in_ready); end
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL lu0_no_bubble got=%h exp=%h", seen(), e); end
    checks++; if (a.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL lu0_stall got=%0d exp=%0d", a.stall_count, exp_stall); end
    @(negedge clk);
  endtask
  task automatic test_no_rt_read;
    a.out_ready = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h8C250000;
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.inst = 32'h20250004;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL nrt_load got=%h exp=%h", seen(), e); end
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL nrt_in_ready got=%b exp=1", a.in_ready); end
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL nrt_addi got=%h exp=%h", seen(), e); end
    @(negedge clk);
  endtask
  task automatic test_flush;
    a.out_ready = 1'b0;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h20250004;
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.inst = 32'h00643020;
    a.flush = 1'b1;
    #1;
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL fl_held got=%b exp=1", a.out_valid); end
    checks++; if (a.in_ready !== 1'b0) begin failures++; $display("FAIL fl_in_ready got=%b exp=0", a.in_ready); end
    @(negedge clk);
    a.flush = 1'b0;
    a.in_valid = 1'b0;
    sb.delete();
    #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL fl_killed got=%b exp=0", a.out_valid); end
    @(negedge clk);
    #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL fl_not_loaded got=%b exp=0", a.out_valid); end
  endtask
  task automatic test_saturation;
    a.out_ready = 1'b0;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h8C250000;
    sb.push_back(model(a.inst));
    @(negedge clk);
    a.inst = 32'hAC450000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (a.in_ready !== 1'b0) begin failures++; $display("FAIL sat_hazard%0d got=%b exp=0", k, a.in_ready); end
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    exp_stall += 5;
    #1;
    checks++; if (a.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL sat_wide got=%0d exp=%0d", a.stall_count, exp_stall); end
    checks++; if (b.stall_count !== 2'd3) begin failures++; $display("FAIL sat_narrow got=%0d exp=3", b.stall_count); end
    e = pop();
    checks++; if (a.out_valid !== 1'b1 || seen() !== e) begin failures++; $display("FAIL sat_load got=%h exp=%h", seen(), e); end
    a.out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain got=%b exp=0", a.out_valid); end
  endtask
  task automatic test_async_reset;
    a.out_ready = 1'b0;
    @(negedge clk);
    a.in_valid = 1'b1;
    a.inst = 32'h2022FFFC;
    @(negedge clk);
    a.in_valid = 1'b0;
    #1;
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b exp=1", a.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", a.out_valid); end
    checks++; if (a.imm !== 32'd0) begin failures++; $display("FAIL ar_imm got=%h exp=0", a.imm); end
    checks++; if (a.stall_count !== 16'd0) begin failures++; $display("FAIL ar_stall got=%0d exp=0", a.stall_count); end
    checks++; if (b.stall_count !== 2'd0) begin failures++; $display("FAIL ar_stall_narrow got=%0d exp=0", b.stall_count); end
    sb.delete();
    exp_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_plain_flow();
    test_backpressure();
    test_back_to_back();
    test_load_use();
    test_no_rt_read();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
